// File: rtl/rfphoenix_mem_bus_dispatch_pkg.sv
// Shared types for the memory request path: request/response records, size and
// function codes, dispatch states and the byte-lane helpers.
package rfphoenix_mem_bus_dispatch_pkg;

  localparam int ADR_W = 32;

  localparam logic [1:0] byt   = 2'd0;
  localparam logic [1:0] wyde  = 2'd1;
  localparam logic [1:0] tetra = 2'd2;
  localparam logic [1:0] octa  = 2'd3;

  localparam logic [3:0] MR_LOAD  = 4'd1;
  localparam logic [3:0] MR_LOADZ = 4'd2;
  localparam logic [3:0] MR_STORE = 4'd3;

  typedef struct packed {
    logic [7:0]       tid;
    logic [3:0]       func;
    logic [1:0]       sz;
    logic [ADR_W-1:0] adr;
    logic [63:0]      dat;
  } sMemoryRequest;

  typedef struct packed {
    logic [7:0]       tid;
    logic [3:0]       func;
    logic [ADR_W-1:0] adr;
    logic [63:0]      dat;
    logic             err;
  } sMemoryResponse;

  // Request fields still needed once the bus cycle is under way.
  typedef struct packed {
    logic [7:0]       tid;
    logic [3:0]       func;
    logic [1:0]       sz;
    logic [ADR_W-1:0] adr;
  } sReqTag;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } dispatch_state_e;

  function automatic logic [15:0] fnSel(input logic [1:0] sz);
    case (sz)
      byt:     fnSel = 16'h0001;
      wyde:    fnSel = 16'h0003;
      tetra:   fnSel = 16'h000F;
      octa:    fnSel = 16'h00FF;
      default: fnSel = 16'h00FF;
    endcase
  endfunction

  function automatic logic [4:0] fnBytes(input logic [1:0] sz);
    case (sz)
      byt:     fnBytes = 5'd1;
      wyde:    fnBytes = 5'd2;
      tetra:   fnBytes = 5'd4;
      octa:    fnBytes = 5'd8;
      default: fnBytes = 5'd8;
    endcase
  endfunction

  function automatic logic fnCrosses(input logic [3:0] adr_lo, input logic [1:0] sz);
    fnCrosses = (({1'b0, adr_lo} + fnBytes(sz)) > 5'd16);
  endfunction

endpackage

// File: rtl/rfphoenix_mem_bus_dispatch_if.sv
// Queue, bus and response signals of the memory bus dispatcher.
interface rfphoenix_mem_bus_dispatch_if
  import rfphoenix_mem_bus_dispatch_pkg::*;
#(
  parameter int AWID = 32
) ();

  logic            q_valid;
  sMemoryRequest   q_req;
  logic            q_rd;
  logic            cyc_o;
  logic            stb_o;
  logic            we_o;
  logic [15:0]     sel_o;
  logic [AWID-1:0] adr_o;
  logic [127:0]    dat_o;
  logic            ack_i;
  logic            err_i;
  logic [127:0]    dat_i;
  logic            resp_valid;
  logic            resp_ready;
  sMemoryResponse  resp;
  logic            busy;

  modport master (
    input  q_valid, q_req, ack_i, err_i, dat_i, resp_ready,
    output q_rd, cyc_o, stb_o, we_o, sel_o, adr_o, dat_o, resp_valid, resp, busy
  );

  modport slave (
    output q_valid, q_req, ack_i, err_i, dat_i, resp_ready,
    input  q_rd, cyc_o, stb_o, we_o, sel_o, adr_o, dat_o, resp_valid, resp, busy
  );

endinterface

// File: rtl/rfphoenix_mem_bus_dispatch_load_align.sv
// Combinational load-data aligner: shifts the addressed lanes down and
// sign- or zero-extends the result to 64 bits.
module rfphoenix_load_align
  import rfphoenix_mem_bus_dispatch_pkg::*;
(
  input  logic [127:0] dat_i,
  input  logic [3:0]   adr_lo,
  input  logic [1:0]   sz,
  input  logic [3:0]   func,
  output logic [63:0]  dat_o
);

  logic [63:0] lane_s;
  logic        sext_s;

  assign lane_s = 64'(dat_i >> {adr_lo, 3'b000});
  assign sext_s = (func == MR_LOAD);

  // Mask to the access size and extend.
  always_comb begin
    dat_o = 64'h0;
    case (sz)
      byt:     dat_o = {{56{sext_s & lane_s[7]}},  lane_s[7:0]};
      wyde:    dat_o = {{48{sext_s & lane_s[15]}}, lane_s[15:0]};
      tetra:   dat_o = {{32{sext_s & lane_s[31]}}, lane_s[31:0]};
      octa:    dat_o = lane_s;
      default: dat_o = lane_s;
    endcase
  end

endmodule

// File: rtl/rfphoenix_mem_bus_dispatch.sv
// Pops one memory request at a time, runs a single classic bus cycle and returns
// a response. Optional bus timeout: define RFPHOENIX_BUS_TIMEOUT_EN.
module rfphoenix_mem_bus_dispatch
  import rfphoenix_mem_bus_dispatch_pkg::*;
#(
  parameter int AWID      = 32,
  parameter int TO_CYCLES = 255
) (
  input logic clk,
  input logic rst,
  rfphoenix_mem_bus_dispatch_if.master bus
);

  if (TO_CYCLES < 1) begin : g_bad_timeout
    $error("TO_CYCLES must be at least 1");
  end

  dispatch_state_e state_q, state_d;
  sReqTag          tag_q, tag_d;
  logic            cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [15:0]     sel_q, sel_d;
  logic [AWID-1:0] adr_q, adr_d;
  logic [127:0]    dat_q, dat_d;
  logic            resp_valid_q, resp_valid_d;
  sMemoryResponse  resp_q, resp_d;
  logic            busy_q, busy_d;
  logic            pop_s, legal_s, term_s, term_err_s, to_hit_s;
  logic [63:0]     load_dat_s;

  rfphoenix_load_align u_align (
    .dat_i  (bus.dat_i),
    .adr_lo (tag_q.adr[3:0]),
    .sz     (tag_q.sz),
    .func   (tag_q.func),
    .dat_o  (load_dat_s)
  );

`ifdef RFPHOENIX_BUS_TIMEOUT_EN
  localparam int TOW = ($clog2(TO_CYCLES) > 8) ? $clog2(TO_CYCLES) : 8;
  logic [TOW-1:0] to_cnt_q, to_cnt_d;

  // Counter runs only while in BUS and is zero on every BUS entry.
  always_comb begin
    if (state_q == ST_BUS) begin
      to_cnt_d = to_cnt_q + TOW'(1);
    end else begin
      to_cnt_d = '0;
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end

  assign to_hit_s = (state_q == ST_BUS) && (to_cnt_q == TOW'(TO_CYCLES - 1));
`else
  assign to_hit_s = 1'b0;
`endif

  assign pop_s = !rst && bus.q_valid &&
                 ((state_q == ST_IDLE) || ((state_q == ST_RESP) && bus.resp_ready));
  assign legal_s = ((bus.q_req.func == MR_LOAD) || (bus.q_req.func == MR_LOADZ) ||
                    (bus.q_req.func == MR_STORE)) &&
                   !fnCrosses(bus.q_req.adr[3:0], bus.q_req.sz);
  assign term_s     = (state_q == ST_BUS) && (bus.ack_i || bus.err_i || to_hit_s);
  assign term_err_s = bus.err_i || to_hit_s;

  // Next-state and output computation; a pop overrides the RESP->IDLE return.
  always_comb begin
    state_d      = state_q;
    tag_d        = tag_q;
    cyc_d        = cyc_q;
    stb_d        = stb_q;
    we_d         = we_q;
    sel_d        = sel_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    resp_valid_d = resp_valid_q;
    resp_d       = resp_q;
    case (state_q)
      ST_IDLE: state_d = ST_IDLE;
      ST_BUS: begin
        if (term_s) begin
          cyc_d        = 1'b0;
          stb_d        = 1'b0;
          we_d         = 1'b0;
          sel_d        = 16'h0;
          adr_d        = '0;
          dat_d        = 128'h0;
          resp_valid_d = 1'b1;
          resp_d.tid   = tag_q.tid;
          resp_d.func  = tag_q.func;
          resp_d.adr   = tag_q.adr;
          resp_d.dat   = (term_err_s || (tag_q.func == MR_STORE)) ? 64'h0 : load_dat_s;
          resp_d.err   = term_err_s;
          state_d      = ST_RESP;
        end else begin
          state_d = ST_BUS;
        end
      end
      ST_RESP: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          resp_d       = '0;
          state_d      = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (pop_s) begin
      tag_d.tid  = bus.q_req.tid;
      tag_d.func = bus.q_req.func;
      tag_d.sz   = bus.q_req.sz;
      tag_d.adr  = bus.q_req.adr;
      if (legal_s) begin
        state_d = ST_BUS;
        cyc_d   = 1'b1;
        stb_d   = 1'b1;
        we_d    = (bus.q_req.func == MR_STORE);
        sel_d   = fnSel(bus.q_req.sz) << bus.q_req.adr[3:0];
        adr_d   = {bus.q_req.adr[AWID-1:4], 4'h0};
        dat_d   = {64'h0, bus.q_req.dat} << {bus.q_req.adr[3:0], 3'b000};
      end else begin
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
        resp_d.tid   = bus.q_req.tid;
        resp_d.func  = bus.q_req.func;
        resp_d.adr   = bus.q_req.adr;
        resp_d.dat   = 64'h0;
        resp_d.err   = 1'b1;
      end
    end else begin
      tag_d = tag_q;
    end
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      tag_q        <= '0;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      we_q         <= 1'b0;
      sel_q        <= 16'h0;
      adr_q        <= '0;
      dat_q        <= 128'h0;
      resp_valid_q <= 1'b0;
      resp_q       <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      tag_q        <= tag_d;
      cyc_q        <= cyc_d;
      stb_q        <= stb_d;
      we_q         <= we_d;
      sel_q        <= sel_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      resp_valid_q <= resp_valid_d;
      resp_q       <= resp_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.q_rd       = pop_s;
  assign bus.cyc_o      = cyc_q;
  assign bus.stb_o      = stb_q;
  assign bus.we_o       = we_q;
  assign bus.sel_o      = sel_q;
  assign bus.adr_o      = adr_q;
  assign bus.dat_o      = dat_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp       = resp_q;
  assign bus.busy       = busy_q;

endmodule
